// File: rtl/dcache_mshr_pkg.sv
// Shared encodings for the dcache miss-status holding registers: Dmem bus
// commands, per-entry MSHR states and dcache address field widths.
package dcache_mshr_pkg;

   localparam int DCACHE_IDX_BITS = 4;
   localparam int DCACHE_BLK_OFF  = 3;
   localparam int DCACHE_TAG_BITS = 64 - DCACHE_BLK_OFF - DCACHE_IDX_BITS;
   localparam int BLK_BITS        = 64 - DCACHE_BLK_OFF;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_t;

   typedef enum logic [1:0] {
      INVALID    = 2'd0,
      WAIT_ISSUE = 2'd1,
      WAIT_DATA  = 2'd2
   } mshr_state_t;

endpackage

// File: rtl/dcache_mshr_entry.sv
// One MSHR slot: lifecycle state, block address, LSQ id, allocation sequence
// number and Dmem ticket, plus the return-tag match compare.
module dcache_mshr_entry
   import dcache_mshr_pkg::*;
#(
   parameter int LSQ_ID_BITS = 3,
   parameter int SEQ_BITS    = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   alloc,
   input  logic [BLK_BITS-1:0]    alloc_blk,
   input  logic [LSQ_ID_BITS-1:0] alloc_lsq_id,
   input  logic [SEQ_BITS-1:0]    alloc_seq,
   input  logic                   grant,
   input  logic [3:0]             response,
   input  logic [3:0]             ret_tag,
   input  logic                   clear,
   output mshr_state_t            state,
   output logic [BLK_BITS-1:0]    blk,
   output logic [LSQ_ID_BITS-1:0] lsq_id,
   output logic [SEQ_BITS-1:0]    seq,
   output logic                   match
);

   mshr_state_t state_q, state_d;
   logic [3:0]  ticket_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= INVALID;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INVALID:    if (alloc) state_d = WAIT_ISSUE;
         WAIT_ISSUE: if (grant) state_d = WAIT_DATA;
         WAIT_DATA:  if (clear) state_d = INVALID;
         default:    state_d = INVALID;
      endcase
   end

   // Payload is only meaningful while the state is not INVALID, so it needs no reset.
   always_ff @(posedge clock) begin
      if (alloc) begin
         blk    <= alloc_blk;
         lsq_id <= alloc_lsq_id;
         seq    <= alloc_seq;
      end
      if (grant) ticket_q <= response;
   end

   assign state = state_q;
   assign match = (state_q == WAIT_DATA) && (ret_tag != 4'd0) && (ticket_q == ret_tag);

endmodule

// File: rtl/dcache_mshr.sv
// dcache MSHR file: allocates load misses, arbitrates the Dmem command port
// between stores and loads, and fills/completes on ticket return.
// Optional MSHR_DUP_CHECK_EN: refuse a miss whose block is already tracked.
module dcache_mshr
   import dcache_mshr_pkg::*;
#(
   parameter int NUM_ENTRIES = 4,
   parameter int LSQ_ID_BITS = 3,
   parameter int IDX_BITS    = DCACHE_IDX_BITS,
   parameter int TAG_BITS    = DCACHE_TAG_BITS
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   miss_valid,
   input  logic [63:0]            miss_addr,
   input  logic [LSQ_ID_BITS-1:0] miss_lsq_id,
   output logic                   miss_ready,
   input  logic                   st_valid,
   input  logic [63:0]            st_addr,
   input  logic [63:0]            st_data,
   output logic                   st_ready,
   output logic [1:0]             Dcache2Dmem_command,
   output logic [63:0]            Dcache2Dmem_addr,
   output logic [63:0]            Dcache2Dmem_data,
   input  logic [3:0]             Dmem2Dcache_response,
   input  logic [3:0]             Dmem2Dcache_tag,
   input  logic [63:0]            Dmem2Dcache_data,
   output logic                   fill_en,
   output logic [IDX_BITS-1:0]    fill_idx,
   output logic [TAG_BITS-1:0]    fill_tag,
   output logic [63:0]            fill_data,
   output logic                   cmpl_valid,
   output logic [LSQ_ID_BITS-1:0] cmpl_lsq_id,
   output logic [63:0]            cmpl_data
);

   localparam int SEQ_BITS = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   mshr_state_t            state  [NUM_ENTRIES];
   logic [BLK_BITS-1:0]    blk    [NUM_ENTRIES];
   logic [LSQ_ID_BITS-1:0] lsq    [NUM_ENTRIES];
   logic [SEQ_BITS-1:0]    seq    [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] match, alloc_sel, alloc_vec, load_sel, grant, hit_sel;

   logic [SEQ_BITS-1:0]    alloc_seq, issue_seq;
   logic                   any_free, dup, load_any, hit_any, do_alloc;
   logic [BLK_BITS-1:0]    load_blk, hit_blk;
   logic [LSQ_ID_BITS-1:0] hit_lsq;
   bus_cmd_t               cmd;
   logic                   unused_addr_bits;

   assign unused_addr_bits = ^{miss_addr[DCACHE_BLK_OFF-1:0], st_addr[DCACHE_BLK_OFF-1:0]};

   for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
      dcache_mshr_entry #(
         .LSQ_ID_BITS (LSQ_ID_BITS),
         .SEQ_BITS    (SEQ_BITS)
      ) u_entry (
         .clock        (clock),
         .reset        (reset),
         .alloc        (alloc_vec[i]),
         .alloc_blk    (miss_addr[63:DCACHE_BLK_OFF]),
         .alloc_lsq_id (miss_lsq_id),
         .alloc_seq    (alloc_seq),
         .grant        (grant[i]),
         .response     (Dmem2Dcache_response),
         .ret_tag      (Dmem2Dcache_tag),
         .clear        (hit_sel[i]),
         .state        (state[i]),
         .blk          (blk[i]),
         .lsq_id       (lsq[i]),
         .seq          (seq[i]),
         .match        (match[i])
      );
   end

   // Allocation: lowest-index free slot, judged on registered state only.
   always_comb begin
      alloc_sel = '0;
      any_free  = 1'b0;
      dup       = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (state[i] == INVALID) begin
            if (!any_free) alloc_sel[i] = 1'b1;
            any_free = 1'b1;
         end else if (blk[i] == miss_addr[63:DCACHE_BLK_OFF]) begin
            dup = 1'b1;
         end
      end
   end

`ifdef MSHR_DUP_CHECK_EN
   assign miss_ready = any_free && !dup;
`else
   assign miss_ready = any_free;
`endif

   assign do_alloc  = miss_valid && miss_ready;
   assign alloc_vec = do_alloc ? alloc_sel : '0;

   // Loads issue strictly in allocation order, so the oldest pending entry is
   // the one whose sequence number equals issue_seq.
   always_comb begin
      load_sel = '0;
      load_any = 1'b0;
      load_blk = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (state[i] == WAIT_ISSUE && seq[i] == issue_seq) begin
            load_sel[i] = 1'b1;
            load_any    = 1'b1;
            load_blk    = blk[i];
         end
      end
   end

   always_comb begin
      cmd              = BUS_NONE;
      Dcache2Dmem_addr = '0;
      Dcache2Dmem_data = '0;
      st_ready         = 1'b0;
      grant            = '0;
      if (st_valid) begin
         cmd              = BUS_STORE;
         Dcache2Dmem_addr = {st_addr[63:DCACHE_BLK_OFF], {DCACHE_BLK_OFF{1'b0}}};
         Dcache2Dmem_data = st_data;
         st_ready         = (Dmem2Dcache_response != 4'd0);
      end else if (load_any) begin
         cmd              = BUS_LOAD;
         Dcache2Dmem_addr = {load_blk, {DCACHE_BLK_OFF{1'b0}}};
         if (Dmem2Dcache_response != 4'd0) grant = load_sel;
      end
   end

   assign Dcache2Dmem_command = cmd;

   // Return: lowest-index match wins should tickets ever collide.
   always_comb begin
      hit_sel = '0;
      hit_any = 1'b0;
      hit_blk = '0;
      hit_lsq = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (match[i] && !hit_any) begin
            hit_sel[i] = 1'b1;
            hit_any    = 1'b1;
            hit_blk    = blk[i];
            hit_lsq    = lsq[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alloc_seq   <= '0;
         issue_seq   <= '0;
         fill_en     <= 1'b0;
         fill_idx    <= '0;
         fill_tag    <= '0;
         fill_data   <= '0;
         cmpl_valid  <= 1'b0;
         cmpl_lsq_id <= '0;
         cmpl_data   <= '0;
      end else begin
         if (do_alloc) alloc_seq <= alloc_seq + SEQ_BITS'(1);
         if (|grant)   issue_seq <= issue_seq + SEQ_BITS'(1);
         fill_en     <= hit_any;
         fill_idx    <= hit_blk[IDX_BITS-1:0];
         fill_tag    <= hit_blk[IDX_BITS +: TAG_BITS];
         fill_data   <= hit_any ? Dmem2Dcache_data : 64'd0;
         cmpl_valid  <= hit_any;
         cmpl_lsq_id <= hit_lsq;
         cmpl_data   <= hit_any ? Dmem2Dcache_data : 64'd0;
      end
   end

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed self-checking bench for dcache_mshr; honours MSHR_DUP_CHECK_EN.
module tb_dcache_mshr;

   logic        clock, reset;
   logic        miss_valid, miss_ready, st_valid, st_ready;
   logic [63:0] miss_addr, st_addr, st_data;
   logic [2:0]  miss_lsq_id;
   logic [1:0]  Dcache2Dmem_command;
   logic [63:0] Dcache2Dmem_addr, Dcache2Dmem_data, Dmem2Dcache_data;
   logic [3:0]  Dmem2Dcache_response, Dmem2Dcache_tag;
   logic        fill_en, cmpl_valid;
   logic [3:0]  fill_idx;
   logic [56:0] fill_tag;
   logic [63:0] fill_data, cmpl_data;
   logic [2:0]  cmpl_lsq_id;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] C_NONE = 2'd0, C_LOAD = 2'd1, C_STORE = 2'd2;

   dcache_mshr dut (
      .clock(clock), .reset(reset),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_lsq_id(miss_lsq_id), .miss_ready(miss_ready),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .Dcache2Dmem_command(Dcache2Dmem_command), .Dcache2Dmem_addr(Dcache2Dmem_addr),
      .Dcache2Dmem_data(Dcache2Dmem_data), .Dmem2Dcache_response(Dmem2Dcache_response),
      .Dmem2Dcache_tag(Dmem2Dcache_tag), .Dmem2Dcache_data(Dmem2Dcache_data),
      .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
      .cmpl_valid(cmpl_valid), .cmpl_lsq_id(cmpl_lsq_id), .cmpl_data(cmpl_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance to just after the next rising edge, clearing one-shot inputs.
   task automatic tick();
      @(posedge clock);
      #1;
      miss_valid = 0; st_valid = 0; Dmem2Dcache_response = 0; Dmem2Dcache_tag = 0;
   endtask

   task automatic test_reset();
      reset = 0; miss_valid = 0; miss_addr = 0; miss_lsq_id = 0; st_valid = 0; st_addr = 0; st_data = 0;
      Dmem2Dcache_response = 0; Dmem2Dcache_tag = 0; Dmem2Dcache_data = 0;
      #2;
      checks++; if (fill_en !== 1'b0) begin errors++; $display("FAIL reset_fill_en got %b exp 0", fill_en); end
      checks++; if (cmpl_valid !== 1'b0) begin errors++; $display("FAIL reset_cmpl_valid got %b exp 0", cmpl_valid); end
      checks++; if (Dcache2Dmem_command !== C_NONE) begin errors++; $display("FAIL reset_cmd got %0d exp 0", Dcache2Dmem_command); end
      checks++; if ({fill_data, cmpl_data, cmpl_lsq_id} !== '0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", fill_data, cmpl_data, cmpl_lsq_id); end
      checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_miss_ready got %b exp 1", miss_ready); end
      tick(); tick();
      reset = 1;
      tick();
   endtask

   task automatic test_single_miss();
      miss_valid = 1; miss_addr = 64'h88; miss_lsq_id = 3'd2;
      #1;
      checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", miss_ready); end
      checks++; if (Dcache2Dmem_command !== C_NONE) begin errors++; $display("FAIL single_noissue_alloc got %0d exp 0", Dcache2Dmem_command); end
      tick();
      Dmem2Dcache_response = 4'd3;
      #1;
      checks++; if (Dcache2Dmem_command !== C_LOAD) begin errors++; $display("FAIL single_cmd got %0d exp 1", Dcache2Dmem_command); end
      checks++; if (Dcache2Dmem_addr !== 64'h88) begin errors++; $display("FAIL single_addr got %h exp 88", Dcache2Dmem_addr); end
      tick();
      #1;
      checks++; if (Dcache2Dmem_command !== C_NONE) begin errors++; $display("FAIL single_after_issue got %0d exp 0", Dcache2Dmem_command); end
      for (int i = 0; i < 5; i++) tick();
      Dmem2Dcache_tag = 4'd3; Dmem2Dcache_data = 64'hCCCC_CCCC_CCCC_CCCC;
      #1;
      checks++; if (fill_en !== 1'b0) begin errors++; $display("FAIL single_early_fill got %b exp 0", fill_en); end
      tick();
      // block 0x88>>3 = 0x11: index 0x1, tag 0x1
      checks++; if (fill_en !== 1'b1 || cmpl_valid !== 1'b1) begin errors++; $display("FAIL single_fill got %b/%b exp 1/1", fill_en, cmpl_valid); end
      checks++; if (fill_idx !== 4'd1 || fill_tag !== 57'd1) begin errors++; $display("FAIL single_idx_tag got %h/%h exp 1/1", fill_idx, fill_tag); end
      checks++; if (cmpl_lsq_id !== 3'd2) begin errors++; $display("FAIL single_lsq got %0d exp 2", cmpl_lsq_id); end
      checks++; if (cmpl_data !== 64'hCCCC_CCCC_CCCC_CCCC || fill_data !== 64'hCCCC_CCCC_CCCC_CCCC) begin errors++; $display("FAIL single_data got %h/%h exp cccc..", cmpl_data, fill_data); end
      tick();
      checks++; if (fill_en !== 1'b0 || cmpl_valid !== 1'b0) begin errors++; $display("FAIL single_one_shot got %b/%b exp 0/0", fill_en, cmpl_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         miss_valid = 1; miss_addr = 64'(i + 1) << 8; miss_lsq_id = 3'(i);
         #1;
         checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d got %b exp 1", i, miss_ready); end
         tick();
      end
      miss_valid = 1; miss_addr = 64'h500; miss_lsq_id = 3'd4;
      #1;
      checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready got %b exp 0", miss_ready); end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         Dmem2Dcache_response = 4'(i + 1);
         #1;
         checks++; if (Dcache2Dmem_command !== C_LOAD || Dcache2Dmem_addr !== (64'(i + 1) << 8)) begin errors++; $display("FAIL full_issue%0d got %0d %h exp 1 %h", i, Dcache2Dmem_command, Dcache2Dmem_addr, 64'(i + 1) << 8); end
      end
      tick();
      Dmem2Dcache_tag = 4'd2; Dmem2Dcache_data = 64'h2222;
      #1;
      checks++; if (Dcache2Dmem_command !== C_NONE) begin errors++; $display("FAIL full_dropped got %0d exp 0", Dcache2Dmem_command); end
      checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL full_still_busy got %b exp 0", miss_ready); end
      tick();
      checks++; if (cmpl_valid !== 1'b1 || cmpl_lsq_id !== 3'd1) begin errors++; $display("FAIL full_ret got %b %0d exp 1 1", cmpl_valid, cmpl_lsq_id); end
      checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got %b exp 1", miss_ready); end
      Dmem2Dcache_tag = 4'd1; tick();
      Dmem2Dcache_tag = 4'd3; tick();
      Dmem2Dcache_tag = 4'd4; tick();
      checks++; if (cmpl_valid !== 1'b1 || cmpl_lsq_id !== 3'd3) begin errors++; $display("FAIL full_drain got %b %0d exp 1 3", cmpl_valid, cmpl_lsq_id); end
      tick();
   endtask

   task automatic test_store_priority();
      miss_valid = 1; miss_addr = 64'h600; miss_lsq_id = 3'd5;
      tick();
      st_valid = 1; st_addr = 64'h1234_5678_9ABC_DEF7; st_data = 64'h55;
      #1;
      checks++; if (Dcache2Dmem_command !== C_STORE || st_ready !== 1'b0) begin errors++; $display("FAIL st_refused got %0d %b exp 2 0", Dcache2Dmem_command, st_ready); end
      tick();
      st_valid = 1; Dmem2Dcache_response = 4'd7;
      #1;
      checks++; if (st_ready !== 1'b1 || Dcache2Dmem_addr !== 64'h1234_5678_9ABC_DEF0 || Dcache2Dmem_data !== 64'h55) begin errors++; $display("FAIL st_accept got %b %h %h exp 1 ..def0 55", st_ready, Dcache2Dmem_addr, Dcache2Dmem_data); end
      tick();
      #1;
      checks++; if (Dcache2Dmem_command !== C_LOAD || Dcache2Dmem_addr !== 64'h600 || Dcache2Dmem_data !== 64'd0) begin errors++; $display("FAIL st_load_retry1 got %0d %h %h exp 1 600 0", Dcache2Dmem_command, Dcache2Dmem_addr, Dcache2Dmem_data); end
      tick();
      #1;
      checks++; if (Dcache2Dmem_command !== C_LOAD) begin errors++; $display("FAIL st_load_retry2 got %0d exp 1", Dcache2Dmem_command); end
      tick();
      Dmem2Dcache_response = 4'd5;
      #1;
      checks++; if (Dcache2Dmem_command !== C_LOAD) begin errors++; $display("FAIL st_load_retry3 got %0d exp 1", Dcache2Dmem_command); end
      tick();
      Dmem2Dcache_tag = 4'd5; Dmem2Dcache_data = 64'h5A5A;
      #1;
      checks++; if (Dcache2Dmem_command !== C_NONE) begin errors++; $display("FAIL st_latched got %0d exp 0", Dcache2Dmem_command); end
      tick();
      checks++; if (cmpl_valid !== 1'b1 || cmpl_lsq_id !== 3'd5 || cmpl_data !== 64'h5A5A) begin errors++; $display("FAIL st_load_cmpl got %b %0d %h exp 1 5 5a5a", cmpl_valid, cmpl_lsq_id, cmpl_data); end
      tick();
   endtask

   task automatic test_out_of_order();
      logic [3:0]  order [3];
      logic [2:0]  exp_lsq [3];
      order = '{4'd3, 4'd1, 4'd2};
      exp_lsq = '{3'd3, 3'd1, 3'd2};
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin miss_valid = 1; miss_addr = 64'hA00 + (64'(i) << 8); miss_lsq_id = 3'(i + 1); end
         if (i > 0) Dmem2Dcache_response = 4'(i);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         Dmem2Dcache_tag = order[i]; Dmem2Dcache_data = 64'hD0 + 64'(order[i]);
         tick();
         checks++; if (cmpl_valid !== 1'b1 || cmpl_lsq_id !== exp_lsq[i] || cmpl_data !== 64'hD0 + 64'(order[i])) begin errors++; $display("FAIL ooo%0d got %b %0d %h exp 1 %0d %h", i, cmpl_valid, cmpl_lsq_id, cmpl_data, exp_lsq[i], 64'hD0 + 64'(order[i])); end
      end
      tick();
      checks++; if (cmpl_valid !== 1'b0) begin errors++; $display("FAIL ooo_idle got %b exp 0", cmpl_valid); end
   endtask

   task automatic test_unknown_and_reset();
      miss_valid = 1; miss_addr = 64'hD00; miss_lsq_id = 3'd6;
      tick();
      Dmem2Dcache_response = 4'd9;
      tick();
      Dmem2Dcache_tag = 4'hF; Dmem2Dcache_data = 64'hFFFF;
      tick();
      checks++; if (fill_en !== 1'b0 || cmpl_valid !== 1'b0) begin errors++; $display("FAIL unknown_tag got %b/%b exp 0/0", fill_en, cmpl_valid); end
      Dmem2Dcache_tag = 4'd9;
      #1 reset = 0;
      #1;
      checks++; if ({fill_en, cmpl_valid, Dcache2Dmem_command, fill_data, cmpl_lsq_id} !== '0) begin errors++; $display("FAIL in_reset got %b %b %0d %h %0d exp 0", fill_en, cmpl_valid, Dcache2Dmem_command, fill_data, cmpl_lsq_id); end
      tick();
      Dmem2Dcache_tag = 4'd9;
      #1;
      checks++; if (fill_en !== 1'b0 || miss_ready !== 1'b1) begin errors++; $display("FAIL in_reset_hold got %b %b exp 0 1", fill_en, miss_ready); end
      tick();
      reset = 1;
      Dmem2Dcache_tag = 4'd9;
      tick();
      checks++; if (fill_en !== 1'b0 || cmpl_valid !== 1'b0) begin errors++; $display("FAIL stale_ticket got %b/%b exp 0/0", fill_en, cmpl_valid); end
   endtask

   task automatic test_dup_block();
      miss_valid = 1; miss_addr = 64'h40; miss_lsq_id = 3'd0;
      tick();
      miss_valid = 1; miss_addr = 64'h40; miss_lsq_id = 3'd1; Dmem2Dcache_response = 4'hA;
      #1;
`ifdef MSHR_DUP_CHECK_EN
      checks++; if (miss_ready !== 1'b0) begin errors++; $display("FAIL dup_refused got %b exp 0", miss_ready); end
      tick();
      #1;
      checks++; if (Dcache2Dmem_command !== C_NONE) begin errors++; $display("FAIL dup_no_second got %0d exp 0", Dcache2Dmem_command); end
      Dmem2Dcache_tag = 4'hA; Dmem2Dcache_data = 64'hAAAA;
      tick();
      checks++; if (cmpl_valid !== 1'b1 || cmpl_lsq_id !== 3'd0) begin errors++; $display("FAIL dup_first got %b %0d exp 1 0", cmpl_valid, cmpl_lsq_id); end
      miss_valid = 1; miss_addr = 64'h40; miss_lsq_id = 3'd1;
      #1;
      checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL dup_retry_ready got %b exp 1", miss_ready); end
      tick();
      Dmem2Dcache_response = 4'hB;
      tick();
`else
      checks++; if (miss_ready !== 1'b1) begin errors++; $display("FAIL dup_accepted got %b exp 1", miss_ready); end
      tick();
      Dmem2Dcache_response = 4'hB;
      #1;
      checks++; if (Dcache2Dmem_command !== C_LOAD || Dcache2Dmem_addr !== 64'h40) begin errors++; $display("FAIL dup_second_issue got %0d %h exp 1 40", Dcache2Dmem_command, Dcache2Dmem_addr); end
      tick();
      Dmem2Dcache_tag = 4'hA; Dmem2Dcache_data = 64'hAAAA;
      tick();
      checks++; if (cmpl_valid !== 1'b1 || cmpl_lsq_id !== 3'd0) begin errors++; $display("FAIL dup_first got %b %0d exp 1 0", cmpl_valid, cmpl_lsq_id); end
`endif
      Dmem2Dcache_tag = 4'hB; Dmem2Dcache_data = 64'hBBBB;
      tick();
      checks++; if (cmpl_valid !== 1'b1 || cmpl_lsq_id !== 3'd1 || fill_idx !== 4'd8 || cmpl_data !== 64'hBBBB) begin errors++; $display("FAIL dup_second got %b %0d %h %h exp 1 1 8 bbbb", cmpl_valid, cmpl_lsq_id, fill_idx, cmpl_data); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_miss();
      test_full();
      test_store_priority();
      test_out_of_order();
      test_unknown_and_reset();
      test_dup_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
